// File: rtl/mchan_synch_array.sv
// Per-ID outstanding command tracker for TCDM and EXT sides.
// Emits busy status, completion pulses and a sticky error report.
module mchan_synch_array #(
  parameter int NB_TRANSFERS    = 16,
  parameter int TRANS_SID_WIDTH = $clog2(NB_TRANSFERS),
  parameter int MCHAN_CMD_WIDTH = 10,
  parameter int CNT_WIDTH       = MCHAN_CMD_WIDTH + 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       mchan_tx_req_i,
  input  logic                       mchan_tx_gnt_i,
  input  logic [TRANS_SID_WIDTH-1:0] mchan_tx_sid_i,
  input  logic [MCHAN_CMD_WIDTH-1:0] mchan_tx_cmd_nb_i,
  input  logic                       mchan_rx_req_i,
  input  logic                       mchan_rx_gnt_i,
  input  logic [TRANS_SID_WIDTH-1:0] mchan_rx_sid_i,
  input  logic [MCHAN_CMD_WIDTH-1:0] mchan_rx_cmd_nb_i,
  input  logic                       tcdm_tx_synch_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] tcdm_tx_synch_sid_i,
  input  logic                       tcdm_rx_synch_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] tcdm_rx_synch_sid_i,
  input  logic                       ext_tx_synch_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] ext_tx_synch_sid_i,
  input  logic                       ext_rx_synch_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] ext_rx_synch_sid_i,
  input  logic                       clr_req_i,
  input  logic [TRANS_SID_WIDTH-1:0] clr_sid_i,
  input  logic                       err_clr_i,
  output logic                       trans_registered_o,
  output logic [NB_TRANSFERS-1:0]    trans_status_o,
  output logic [NB_TRANSFERS-1:0]    term_sig_o,
  output logic                       err_o,
  output logic [TRANS_SID_WIDTH-1:0] err_sid_o
);

  localparam int SW = CNT_WIDTH + 1;
  localparam logic [SW-1:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

  logic [CNT_WIDTH-1:0] tcdm_cnt_q [NB_TRANSFERS];
  logic [CNT_WIDTH-1:0] tcdm_cnt_d [NB_TRANSFERS];
  logic [CNT_WIDTH-1:0] ext_cnt_q  [NB_TRANSFERS];
  logic [CNT_WIDTH-1:0] ext_cnt_d  [NB_TRANSFERS];
  logic [SW-1:0]        inc        [NB_TRANSFERS];
  logic [SW-1:0]        dec_t      [NB_TRANSFERS];
  logic [SW-1:0]        dec_e      [NB_TRANSFERS];
  logic [CNT_WIDTH:0]   res_t      [NB_TRANSFERS];
  logic [CNT_WIDTH:0]   res_e      [NB_TRANSFERS];

  logic [NB_TRANSFERS-1:0]    pending, pending_q, clr_q, clr_d, err_id;
  logic                       tx_hs, rx_hs, any_err;
  logic                       err_q, err_d;
  logic [TRANS_SID_WIDTH-1:0] err_sid_q, err_sid_d, low_sid;

  // {error, saturated count} for one side of one ID
  function automatic logic [CNT_WIDTH:0] upd(
    input logic [SW-1:0] up,
    input logic [SW-1:0] dn
  );
    logic [SW-1:0] n;
    if (up < dn) return {1'b1, {CNT_WIDTH{1'b0}}};
    n = up - dn;
    if (n > CNT_MAX) return {1'b1, CNT_MAX[CNT_WIDTH-1:0]};
    return {1'b0, n[CNT_WIDTH-1:0]};
  endfunction

  assign tx_hs = mchan_tx_req_i & mchan_tx_gnt_i;
  assign rx_hs = mchan_rx_req_i & mchan_rx_gnt_i;
  assign trans_registered_o = tx_hs | rx_hs;

  always_comb begin
    for (int i = 0; i < NB_TRANSFERS; i++) begin
      logic [TRANS_SID_WIDTH-1:0] id;
      id       = TRANS_SID_WIDTH'(i);
      inc[i]   = '0;
      if (tx_hs && mchan_tx_sid_i == id)
        inc[i] = inc[i] + SW'(mchan_tx_cmd_nb_i);
      if (rx_hs && mchan_rx_sid_i == id)
        inc[i] = inc[i] + SW'(mchan_rx_cmd_nb_i);
      dec_t[i] = SW'(tcdm_tx_synch_req_i && tcdm_tx_synch_sid_i == id)
               + SW'(tcdm_rx_synch_req_i && tcdm_rx_synch_sid_i == id);
      dec_e[i] = SW'(ext_tx_synch_req_i && ext_tx_synch_sid_i == id)
               + SW'(ext_rx_synch_req_i && ext_rx_synch_sid_i == id);
      res_t[i] = upd({1'b0, tcdm_cnt_q[i]} + inc[i], dec_t[i]);
      res_e[i] = upd({1'b0, ext_cnt_q[i]} + inc[i], dec_e[i]);
      clr_d[i] = clr_req_i && clr_sid_i == id;
      // abort wins over any arithmetic or error on that ID
      if (clr_d[i]) begin
        tcdm_cnt_d[i] = '0;
        ext_cnt_d[i]  = '0;
        err_id[i]     = 1'b0;
      end else begin
        tcdm_cnt_d[i] = res_t[i][CNT_WIDTH-1:0];
        ext_cnt_d[i]  = res_e[i][CNT_WIDTH-1:0];
        err_id[i]     = res_t[i][CNT_WIDTH] | res_e[i][CNT_WIDTH];
      end
      pending[i] = (tcdm_cnt_q[i] != '0) | (ext_cnt_q[i] != '0);
    end
  end

  always_comb begin
    low_sid = '0;
    for (int i = NB_TRANSFERS - 1; i >= 0; i--)
      if (err_id[i]) low_sid = TRANS_SID_WIDTH'(i);
    any_err   = |err_id;
    err_d     = any_err ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    err_sid_d = (!err_q && any_err) ? low_sid : err_sid_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_TRANSFERS; i++) begin
        tcdm_cnt_q[i] <= '0;
        ext_cnt_q[i]  <= '0;
      end
      pending_q <= '0;
      clr_q     <= '0;
      err_q     <= 1'b0;
      err_sid_q <= '0;
    end else begin
      for (int i = 0; i < NB_TRANSFERS; i++) begin
        tcdm_cnt_q[i] <= tcdm_cnt_d[i];
        ext_cnt_q[i]  <= ext_cnt_d[i];
      end
      pending_q <= pending;
      clr_q     <= clr_d;
      err_q     <= err_d;
      err_sid_q <= err_sid_d;
    end
  end

  assign trans_status_o = pending | pending_q;
  assign term_sig_o     = pending_q & ~pending & ~clr_q;
  assign err_o          = err_q;
  assign err_sid_o      = err_sid_q;

endmodule
